// File: rtl/spi_pkg.sv
// Shared SPI constants: mode encodings and divisor sizing for the baud-rate generator.
package spi_pkg;

    localparam int unsigned DIV_W = 12;

    localparam logic [1:0] SPI_MODE_RUN  = 2'b00;
    localparam logic [1:0] SPI_MODE_WAIT = 2'b01;
    localparam logic [1:0] SPI_MODE_STOP = 2'b10;

    localparam int unsigned SPI_DIV_MIN = 2;

endpackage

// File: rtl/spi_baud_divisor.sv
// Baud divisor (sppr+1) << (spr+1), latched while idle and frozen for the duration of a transfer.
module spi_baud_divisor #(
    parameter int unsigned DIV_W = 12
) (
    input  logic             PCLK,
    input  logic             PRESETn,
    input  logic             load_en,
    input  logic [2:0]       sppr,
    input  logic [2:0]       spr,
    output logic [DIV_W-1:0] baud_divisor
);
    import spi_pkg::*;

    logic [DIV_W-1:0] div_d;
    logic [3:0]       shamt;

    // Shift amount needs 4 bits: spr=7 gives a shift of 8.
    always_comb begin
        shamt = {1'b0, spr} + 4'd1;
        div_d = (DIV_W'(sppr) + DIV_W'(1)) << shamt;
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            baud_divisor <= DIV_W'(SPI_DIV_MIN);
        end else if (load_en) begin
            baud_divisor <= div_d;
        end
    end

endmodule

// File: rtl/spi_baud_gen.sv
// SPI master baud-rate generator: sclk divider plus registered MOSI-shift / MISO-sample strobes.
// Define SPI_BAUD_WAIT_STOP_EN to let spiswai stop the clock in wait mode.
module spi_baud_gen #(
    parameter int unsigned DIV_W = spi_pkg::DIV_W
) (
    input  logic             PCLK,
    input  logic             PRESETn,
    input  logic             ss,
    input  logic [1:0]       spi_mode,
    input  logic             spiswai,
    input  logic             cpol,
    input  logic             cpha,
    input  logic [2:0]       sppr,
    input  logic [2:0]       spr,
    output logic             sclk,
    output logic             flag_low,
    output logic             flag_high,
    output logic             flags_low,
    output logic             flags_high,
    output logic [DIV_W-1:0] baud_divisor
);
    import spi_pkg::*;

    logic             active;
    logic [DIV_W-1:0] half, half_m1, shift_pt;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             sclk_d;
    logic             flag_low_d, flag_high_d, flags_low_d, flags_high_d;

    // cpha only steers strobe selection downstream; it is not used here.
    logic unused_cpha;
    assign unused_cpha = cpha;

`ifdef SPI_BAUD_WAIT_STOP_EN
    assign active = !ss && ((spi_mode == SPI_MODE_RUN) ||
                            ((spi_mode == SPI_MODE_WAIT) && !spiswai));
`else
    logic unused_spiswai;
    assign unused_spiswai = spiswai;
    assign active = !ss && ((spi_mode == SPI_MODE_RUN) || (spi_mode == SPI_MODE_WAIT));
`endif

    spi_baud_divisor #(
        .DIV_W (DIV_W)
    ) u_divisor (
        .PCLK         (PCLK),
        .PRESETn      (PRESETn),
        .load_en      (!active),
        .sppr         (sppr),
        .spr          (spr),
        .baud_divisor (baud_divisor)
    );

    always_comb begin
        half         = baud_divisor >> 1;
        half_m1      = half - DIV_W'(1);
        // With half==1 the shift strobe folds onto the sample strobe instead of underflowing.
        shift_pt     = (half == DIV_W'(1)) ? '0 : half - DIV_W'(2);
        cnt_d        = '0;
        sclk_d       = cpol;
        flag_low_d   = 1'b0;
        flag_high_d  = 1'b0;
        flags_low_d  = 1'b0;
        flags_high_d = 1'b0;
        if (active) begin
            flag_high_d  = sclk  && (cnt_q == half_m1);
            flag_low_d   = !sclk && (cnt_q == half_m1);
            flags_high_d = sclk  && (cnt_q == shift_pt);
            flags_low_d  = !sclk && (cnt_q == shift_pt);
            if (cnt_q >= half_m1) begin
                cnt_d  = '0;
                sclk_d = !sclk;
            end else begin
                cnt_d  = cnt_q + DIV_W'(1);
                sclk_d = sclk;
            end
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            cnt_q      <= '0;
            sclk       <= 1'b0;
            flag_low   <= 1'b0;
            flag_high  <= 1'b0;
            flags_low  <= 1'b0;
            flags_high <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            sclk       <= sclk_d;
            flag_low   <= flag_low_d;
            flag_high  <= flag_high_d;
            flags_low  <= flags_low_d;
            flags_high <= flags_high_d;
        end
    end

endmodule
